// File: rtl/ext_cpu_obi_pkg.sv
// OBI request/response bundles shared by the hart-side and bus-side ports of the data-port arbiter.
// Field order matches the packed layout used on every OBI link in this subsystem.
package ext_cpu_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin N-to-1 OBI data-port arbiter; responses return in order to the issuing hart.
// Latency: request/gnt pass through combinationally; rvalid is routed combinationally to the ID FIFO head.
// Backpressure: bus gnt flows to the selected hart only; a full ID FIFO withholds bus req unless a response frees a slot.
module ext_cpu_obi_arbiter
    import ext_cpu_obi_pkg::*;
#(
    parameter int NHARTS          = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  obi_req_t                         core_req_i [NHARTS],
    output obi_resp_t                        core_resp_o [NHARTS],
    output obi_req_t                         bus_req_o,
    input  obi_resp_t                        bus_resp_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             proto_err_o
);

    localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_idx;
    logic          lock;
    logic [IW-1:0] sel;
    logic [IW-1:0] scan_idx;
    logic          found;

    logic [IW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] head_id;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          req_blocked;

    assign fifo_full     = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty    = (count == '0);
    assign head_id       = id_mem[rd_ptr];
    assign outstanding_o = count;

    // A locked request keeps its hart selected until granted (OBI stability rule).
    always_comb begin
        sel      = rr_ptr;
        scan_idx = rr_ptr;
        found    = 1'b0;
        for (int i = 0; i < NHARTS; i++) begin
            scan_idx = IW'((int'(rr_ptr) + i) % NHARTS);
            if (!found && core_req_i[scan_idx].req) begin
                sel   = scan_idx;
                found = 1'b1;
            end
        end
        if (lock) begin
            sel = lock_idx;
        end
    end

    // A full FIFO still accepts when the same-cycle response pops a slot.
    assign pop         = bus_resp_i.rvalid && !fifo_empty;
    assign req_blocked = fifo_full && !pop;
    assign push        = bus_req_o.req && bus_resp_i.gnt;

    always_comb begin
        bus_req_o     = core_req_i[sel];
        bus_req_o.req = core_req_i[sel].req && !req_blocked;
    end

    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            core_resp_o[h]        = '0;
            core_resp_o[h].gnt    = push && (sel == IW'(h));
            core_resp_o[h].rvalid = pop && (head_id == IW'(h));
            core_resp_o[h].rdata  = bus_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            lock        <= 1'b0;
            lock_idx    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if (push) begin
                lock   <= 1'b0;
                rr_ptr <= (sel == IW'(NHARTS - 1)) ? '0 : sel + 1'b1;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end else if (bus_req_o.req) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus_resp_i.rvalid && fifo_empty) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_ext_cpu_obi_arbiter.sv
// Directed bench for ext_cpu_obi_arbiter: queue-based reference model checked every negedge plus literal spot checks.
module tb_ext_cpu_obi_arbiter;
    import ext_cpu_obi_pkg::*;

    localparam int NH = 2;
    localparam int MO = 2;

    logic              clk = 1'b0;
    logic              rst;
    obi_req_t          core_req  [NH];
    obi_resp_t         core_resp [NH];
    obi_req_t          bus_req;
    obi_resp_t         bus_resp;
    logic [$clog2(MO):0] outstanding;
    logic              perr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of issuing harts, rotating priority, pending-lock hart (-1 = none).
    int mq[$];
    int m_rr   = 0;
    int m_lock = -1;
    bit m_perr = 1'b0;

    ext_cpu_obi_arbiter #(.NHARTS(NH), .MAX_OUTSTANDING(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_resp_o  (core_resp),
        .bus_req_o    (bus_req),
        .bus_resp_i   (bus_resp),
        .outstanding_o(outstanding),
        .proto_err_o  (perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gnt_hart();
        int r = -1;
        for (int h = 0; h < NH; h++) if (core_resp[h].gnt) r = h;
        return r;
    endfunction

    function automatic int rv_hart();
        int r = -1;
        for (int h = 0; h < NH; h++) if (core_resp[h].rvalid) r = h;
        return r;
    endfunction

    function automatic obi_req_t mk(input logic req, input logic [31:0] addr, input logic we);
        obi_req_t r;
        r.req   = req;
        r.we    = we;
        r.be    = 4'hF;
        r.addr  = addr;
        r.wdata = addr ^ 32'hA5A5_0000;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : model
        int sel;
        int hx;
        int head;
        bit found;
        bit pop;
        bit ereq;
        bit acc;
        if (rst) begin
            mq.delete();
            m_rr   = 0;
            m_lock = -1;
            m_perr = 1'b0;
        end
        if (m_lock >= 0) begin
            sel = m_lock;
        end else begin
            sel   = m_rr;
            found = 1'b0;
            for (int i = 0; i < NH; i++) begin
                hx = (m_rr + i) % NH;
                if (!found && core_req[hx].req) begin
                    sel   = hx;
                    found = 1'b1;
                end
            end
        end
        pop  = bus_resp.rvalid && (mq.size() > 0);
        head = pop ? mq[0] : -1;
        ereq = core_req[sel].req && !((mq.size() == MO) && !pop);
        acc  = ereq && bus_resp.gnt;

        chk("m_outstanding", 32'(outstanding), mq.size());
        chk("m_proto_err", perr, m_perr);
        chk("m_bus_req", bus_req.req, ereq);
        if (ereq) begin
            chk("m_bus_addr", bus_req.addr, core_req[sel].addr);
            chk("m_bus_we", bus_req.we, core_req[sel].we);
            chk("m_bus_be", bus_req.be, core_req[sel].be);
            chk("m_bus_wdata", bus_req.wdata, core_req[sel].wdata);
        end
        for (int h = 0; h < NH; h++) begin
            chk("m_gnt", core_resp[h].gnt, acc && (h == sel));
            chk("m_rvalid", core_resp[h].rvalid, (head == h));
        end
        if (pop) chk("m_rdata", core_resp[head].rdata, bus_resp.rdata);

        if (!rst) begin
            if (bus_resp.rvalid && mq.size() == 0) m_perr = 1'b1;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(sel);
                m_rr   = (sel + 1) % NH;
                m_lock = -1;
            end else if (ereq) begin
                m_lock = sel;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int h = 0; h < NH; h++) core_req[h] = '0;
        bus_resp = '0;
        repeat (2) cyc();

        // Reset state, idle harts
        rst = 1'b0;
        #1;
        chk("t1_bus_req", bus_req.req, 1'b0);
        chk("t1_outstanding", 32'(outstanding), 0);
        chk("t1_proto_err", perr, 1'b0);
        chk("t1_gnt", gnt_hart(), -1);
        chk("t1_rvalid", rv_hart(), -1);
        cyc();

        // Both harts requesting every cycle, responses one cycle behind grants
        core_req[0] = mk(1'b1, 32'h1000, 1'b1);
        core_req[1] = mk(1'b1, 32'h2000, 1'b0);
        bus_resp.gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_gnt", gnt_hart(), k % 2);
            chk("t2_addr", bus_req.addr, (k % 2) ? 32'h2000 : 32'h1000);
            if (k > 0) begin
                chk("t2_rv", rv_hart(), (k - 1) % 2);
                chk("t2_rdata", core_resp[(k - 1) % 2].rdata, 32'hD0 + k - 1);
            end
            cyc();
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = 32'hD0 + k;
        end
        core_req[0] = '0;
        core_req[1] = '0;
        bus_resp.gnt = 1'b0;
        #1;
        chk("t2_rv_last", rv_hart(), 1);
        chk("t2_req_idle", bus_req.req, 1'b0);
        cyc();
        bus_resp.rvalid = 1'b0;
        #1;
        chk("t2_drained", 32'(outstanding), 0);
        cyc();

        // Stalled request stays locked while another hart arrives
        core_req[1] = mk(1'b1, 32'h100, 1'b0);
        #1;
        chk("t3_addr_c0", bus_req.addr, 32'h100);
        chk("t3_nognt", gnt_hart(), -1);
        cyc();
        core_req[0] = mk(1'b1, 32'h200, 1'b1);
        #1;
        chk("t3_addr_c1", bus_req.addr, 32'h100);
        cyc();
        #1;
        chk("t3_addr_c2", bus_req.addr, 32'h100);
        cyc();
        bus_resp.gnt = 1'b1;
        #1;
        chk("t3_gnt_h1", gnt_hart(), 1);
        chk("t3_addr_gnt", bus_req.addr, 32'h100);
        cyc();
        core_req[1] = '0;
        #1;
        chk("t3_gnt_h0", gnt_hart(), 0);
        chk("t3_addr_h0", bus_req.addr, 32'h200);
        cyc();
        core_req[0] = '0;
        bus_resp.gnt    = 1'b0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hE1;
        #1;
        chk("t3_rv_h1", rv_hart(), 1);
        chk("t3_rdata_h1", core_resp[1].rdata, 32'hE1);
        cyc();
        bus_resp.rdata = 32'hE2;
        #1;
        chk("t3_rv_h0", rv_hart(), 0);
        cyc();
        bus_resp.rvalid = 1'b0;

        // FIFO fills, then a response makes room for a same-cycle grant
        core_req[0] = mk(1'b1, 32'h300, 1'b0);
        core_req[1] = mk(1'b1, 32'h400, 1'b1);
        bus_resp.gnt = 1'b1;
        #1;
        chk("t4_gnt_a", gnt_hart(), 1);
        cyc();
        #1;
        chk("t4_gnt_b", gnt_hart(), 0);
        cyc();
        #1;
        chk("t4_full_cnt", 32'(outstanding), 2);
        chk("t4_full_req", bus_req.req, 1'b0);
        chk("t4_full_gnt", gnt_hart(), -1);
        cyc();
        core_req[1] = '0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hF1;
        #1;
        chk("t4_pp_req", bus_req.req, 1'b1);
        chk("t4_pp_gnt", gnt_hart(), 0);
        chk("t4_pp_rv", rv_hart(), 1);
        cyc();
        core_req[0] = '0;
        bus_resp.gnt    = 1'b0;
        bus_resp.rvalid = 1'b0;
        #1;
        chk("t4_pp_cnt", 32'(outstanding), 2);
        cyc();

        // Asynchronous reset with two outstanding, then priority restarts at hart 0
        rst = 1'b1;
        #1;
        chk("t6_async_cnt", 32'(outstanding), 0);
        chk("t6_async_perr", perr, 1'b0);
        cyc();
        rst = 1'b0;
        core_req[0] = mk(1'b1, 32'h500, 1'b0);
        core_req[1] = mk(1'b1, 32'h600, 1'b0);
        bus_resp.gnt = 1'b1;
        #1;
        chk("t6_first_gnt", gnt_hart(), 0);
        cyc();
        core_req[0] = '0;
        core_req[1] = '0;
        bus_resp.gnt    = 1'b0;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hA1;
        #1;
        chk("t6_rv_h0", rv_hart(), 0);
        cyc();
        #1;
        chk("t6_stray_rv", rv_hart(), -1);
        cyc();
        bus_resp.rvalid = 1'b0;
        #1;
        chk("t6_perr_set", perr, 1'b1);
        repeat (3) cyc();
        chk("t6_perr_sticky", perr, 1'b1);

        // Response with nothing outstanding right after reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_perr_clr", perr, 1'b0);
        cyc();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hBAD;
        #1;
        chk("t5_no_rv", rv_hart(), -1);
        cyc();
        bus_resp.rvalid = 1'b0;
        #1;
        chk("t5_perr", perr, 1'b1);
        repeat (2) cyc();
        chk("t5_perr_sticky", perr, 1'b1);
        chk("t5_cnt", 32'(outstanding), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
